// File: rtl/lcd_text_ctrl.sv
`timescale 1ns/1ps
// HD44780 text controller: runs the power-up init sequence, then writes one
// fixed-text message per request to line 0 or 1, skipping redundant rewrites.
module lcd_text_ctrl #(
  parameter int CLK_HZ    = 12000000,
  parameter int NUM_LINES = 2,
  parameter int NUM_COLS  = 16,
  parameter int MSG_W     = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_msg_valid,
  input  logic [MSG_W-1:0] i_msg_id,
  input  logic             i_line,
  output logic             o_msg_ready,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_EN,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             LCD_ON,
  output logic             LCD_BLON
);

  function automatic int us_to_cyc(input longint t_us);
    return int'((longint'(CLK_HZ) * t_us + longint'(999999)) / longint'(1000000));
  endfunction

  localparam int EN_CYC  = (CLK_HZ + 1999999) / 2000000;
  localparam int PWR_CYC = us_to_cyc(15000);
  localparam int W_4100  = us_to_cyc(4100);
  localparam int W_1530  = us_to_cyc(1530);
  localparam int W_100   = us_to_cyc(100);
  localparam int W_43    = us_to_cyc(43);
  localparam int W_39    = us_to_cyc(39);
  localparam int TW      = $clog2(PWR_CYC + 1);
  localparam int CW      = $clog2(NUM_COLS);
  localparam logic [7:0] FUNCSET = (NUM_LINES == 2) ? 8'h38 : 8'h30;

  typedef enum logic [2:0] {PWR_WAIT, INIT_CMD, IDLE, ADDR, CHAR} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [2:0]             idx_q, idx_d;
  logic [CW-1:0]          col_q, col_d;
  logic [MSG_W-1:0]       msg_q, msg_d;
  logic                   line_q, line_d;
  logic [1:0]             last_vld_q, last_vld_d;
  logic [1:0][MSG_W-1:0]  last_id_q, last_id_d;

  logic                   writing, wr_done, wr_rs, line_eff, hit;
  logic [7:0]             wr_data;
  logic [TW-1:0]          wr_last;

  // Text ROM: every message fits in six characters, the rest is blank padding.
  function automatic logic [7:0] rom_char(input logic [MSG_W-1:0] id, input logic [CW-1:0] col);
    logic [47:0] text;
    int c;
    case (int'(id))
      1:       text = "IDLE  ";
      2:       text = "RECORD";
      3:       text = "STOP  ";
      4:       text = "PLAY  ";
      5:       text = "PAUSE ";
      default: text = "      ";
    endcase
    c = int'(col);
    if (c < 6) return text[8*(5-c) +: 8];
    return 8'h20;
  endfunction

  function automatic logic [7:0] init_data(input logic [2:0] idx);
    case (idx)
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      3'd5:    return 8'h06;
      default: return FUNCSET;
    endcase
  endfunction

  function automatic logic [TW-1:0] init_wait(input logic [2:0] idx);
    case (idx)
      3'd0:    return TW'(W_4100);
      3'd1:    return TW'(W_100);
      3'd4:    return TW'(W_1530);
      default: return TW'(W_39);
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= PWR_WAIT;
      tmr_q      <= '0;
      idx_q      <= '0;
      col_q      <= '0;
      msg_q      <= '0;
      line_q     <= 1'b0;
      last_vld_q <= '0;
      last_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      msg_q      <= msg_d;
      line_q     <= line_d;
      last_vld_q <= last_vld_d;
      last_id_q  <= last_id_d;
    end
  end

  // A bus write spans tmr 0 (setup), 1..EN_CYC (strobe), then the wait time.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    col_d      = col_q;
    msg_d      = msg_q;
    line_d     = line_q;
    last_vld_d = last_vld_q;
    last_id_d  = last_id_q;
    writing    = 1'b0;
    wr_data    = 8'h00;
    wr_rs      = 1'b0;
    wr_last    = '0;
    line_eff   = (NUM_LINES == 1) ? 1'b0 : i_line;
    hit        = last_vld_q[line_eff] && (last_id_q[line_eff] == i_msg_id);

    case (state_q)
      INIT_CMD: begin
        writing = 1'b1;
        wr_data = init_data(idx_q);
        wr_last = TW'(EN_CYC) + init_wait(idx_q);
      end
      ADDR: begin
        writing = 1'b1;
        wr_data = line_q ? 8'hC0 : 8'h80;
        wr_last = TW'(EN_CYC + W_43);
      end
      CHAR: begin
        writing = 1'b1;
        wr_rs   = 1'b1;
        wr_data = rom_char(msg_q, col_q);
        wr_last = TW'(EN_CYC + W_43);
      end
      default: ;
    endcase

    wr_done = writing && (tmr_q == wr_last);
    if (writing) tmr_d = wr_done ? '0 : tmr_q + TW'(1);

    case (state_q)
      PWR_WAIT: begin
        if (tmr_q == TW'(PWR_CYC - 1)) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = INIT_CMD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      INIT_CMD: begin
        if (wr_done) begin
          if (idx_q == 3'd5) state_d = IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      IDLE: begin
        if (i_msg_valid && !hit) begin
          msg_d   = i_msg_id;
          line_d  = line_eff;
          col_d   = '0;
          tmr_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (wr_done) state_d = CHAR;
      end
      CHAR: begin
        if (wr_done) begin
          if (col_q == CW'(NUM_COLS - 1)) begin
            state_d            = IDLE;
            last_vld_d[line_q] = 1'b1;
            last_id_d[line_q]  = msg_q;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  assign o_msg_ready = (state_q == IDLE);
  assign LCD_EN      = writing && (tmr_q != '0) && (tmr_q <= TW'(EN_CYC));
  assign LCD_DATA    = wr_data;
  assign LCD_RS      = wr_rs;
  assign LCD_RW      = 1'b0;
  assign LCD_ON      = 1'b1;
  assign LCD_BLON    = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lcd_text_ctrl: a 2-line/16-col instance at 500 kHz and a
// 1-line/8-col instance at 2.1 MHz, so all delays stay short but ceil() matters.
module tb_lcd_text_ctrl;
  localparam int MSG_W  = 3;
  localparam int GAP_A  = 24;
  localparam int MSG_A  = 17 * GAP_A;
  localparam int INIT_A = 10437;
  localparam int GAP_B  = 94;
  localparam int MSG_B  = 9 * GAP_B;
  localparam int INIT_B = 43797;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         en_len;
    longint     start;
    logic       ok;
  } bus_rec_t;

  typedef struct {
    logic [MSG_W-1:0] id;
    logic             line;
    logic             wr;
    logic [7:0]       addr;
    string            text;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, valid_a, valid_b, line_a, line_b;
  logic [MSG_W-1:0] id_a, id_b;
  logic rdy_a, rdy_b, en_a, en_b, rs_a, rs_b, rw_a, rw_b, on_a, on_b, blon_a, blon_b;
  logic [7:0] data_a, data_b;

  longint cyc = 0;
  longint acc_cyc = 0;
  longint rel_b = 0;
  longint rdy_b_cyc = -1;
  int n_checks = 0;
  int n_pass = 0;

  bus_rec_t mon_a_q[$], mon_b_q[$];
  bus_rec_t cur_a, cur_b;
  logic prev_en_a = 1'b0, prev_en_b = 1'b0, prev_rs_a = 1'b0, prev_rs_b = 1'b0;
  logic [7:0] prev_data_a = 8'h00, prev_data_b = 8'h00;

  logic [7:0] exp_data_q[$];
  logic       exp_rs_q[$];
  int         exp_gap_q[$];

  lcd_text_ctrl #(.CLK_HZ(500000), .NUM_LINES(2), .NUM_COLS(16), .MSG_W(MSG_W)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_msg_valid(valid_a), .i_msg_id(id_a), .i_line(line_a),
    .o_msg_ready(rdy_a), .LCD_DATA(data_a), .LCD_EN(en_a), .LCD_RS(rs_a), .LCD_RW(rw_a),
    .LCD_ON(on_a), .LCD_BLON(blon_a)
  );

  lcd_text_ctrl #(.CLK_HZ(2100000), .NUM_LINES(1), .NUM_COLS(8), .MSG_W(MSG_W)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_msg_valid(valid_b), .i_msg_id(id_b), .i_line(line_b),
    .o_msg_ready(rdy_b), .LCD_DATA(data_b), .LCD_EN(en_b), .LCD_RS(rs_b), .LCD_RW(rw_b),
    .LCD_ON(on_b), .LCD_BLON(blon_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitors: one record per EN pulse, with setup/hold stability folded into ok.
  always @(negedge clk) begin
    if (en_a && !prev_en_a) begin
      cur_a.data   = data_a;
      cur_a.rs     = rs_a;
      cur_a.en_len = 1;
      cur_a.start  = cyc;
      cur_a.ok     = (prev_data_a == data_a) && (prev_rs_a == rs_a);
    end else if (en_a && prev_en_a) begin
      cur_a.en_len = cur_a.en_len + 1;
      if (data_a != cur_a.data || rs_a != cur_a.rs) cur_a.ok = 1'b0;
    end else if (!en_a && prev_en_a) begin
      mon_a_q.push_back(cur_a);
    end
    prev_en_a = en_a; prev_data_a = data_a; prev_rs_a = rs_a;
  end

  always @(negedge clk) begin
    if (en_b && !prev_en_b) begin
      cur_b.data   = data_b;
      cur_b.rs     = rs_b;
      cur_b.en_len = 1;
      cur_b.start  = cyc;
      cur_b.ok     = (prev_data_b == data_b) && (prev_rs_b == rs_b);
    end else if (en_b && prev_en_b) begin
      cur_b.en_len = cur_b.en_len + 1;
      if (data_b != cur_b.data || rs_b != cur_b.rs) cur_b.ok = 1'b0;
    end else if (!en_b && prev_en_b) begin
      mon_b_q.push_back(cur_b);
    end
    prev_en_b = en_b; prev_data_b = data_b; prev_rs_b = rs_b;
    if (rdy_b && rdy_b_cyc < 0) rdy_b_cyc = cyc;
  end

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  task automatic clearExpect();
    exp_data_q.delete(); exp_rs_q.delete(); exp_gap_q.delete();
  endtask

  task automatic expectInit(input logic [7:0] fs, input int g0, input int g1, input int g2,
                            input int g3, input int g4);
    clearExpect();
    exp_data_q = '{fs, fs, fs, 8'h0C, 8'h01, 8'h06};
    exp_rs_q   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_gap_q  = '{g0, g1, g2, g3, g4};
  endtask

  task automatic expectMessage(input logic [7:0] addr, input string text, input int ncols,
                               input int gap);
    clearExpect();
    exp_data_q.push_back(addr);
    exp_rs_q.push_back(1'b0);
    for (int i = 0; i < ncols; i++) begin
      exp_data_q.push_back((i < text.len()) ? 8'(text[i]) : 8'h20);
      exp_rs_q.push_back(1'b1);
      exp_gap_q.push_back(gap);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [MSG_W-1:0] id, input logic ln);
    @(negedge clk);
    if (sel) begin mon_b_q.delete(); valid_b = 1'b1; id_b = id; line_b = ln; end
    else     begin mon_a_q.delete(); valid_a = 1'b1; id_a = id; line_a = ln; end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (sel) begin valid_b = 1'b0; id_b = ~id; line_b = ~ln; end
    else     begin valid_a = 1'b0; id_a = ~id; line_a = ~ln; end
  endtask

  task automatic waitReady(input bit sel, input int bound, output longint lat);
    int guard = 0;
    while (!(sel ? rdy_b : rdy_a) && guard < bound) begin
      @(posedge clk);
      #1;
      guard++;
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic checkIdleQuiet(input bit sel, input string name);
    int lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (!(sel ? rdy_b : rdy_a)) lows++;
    end
    check({name, " ready held"}, lows, 0);
  endtask

  task automatic checkOutput(input string name, input bit sel, input int en_len);
    bus_rec_t got[$];
    if (sel) got = mon_b_q;
    else     got = mon_a_q;
    check({name, " write count"}, got.size(), exp_data_q.size());
    foreach (exp_data_q[i]) begin
      bus_rec_t r;
      r = '{data: 8'h00, rs: 1'b0, en_len: 0, start: 0, ok: 1'b0};
      if (i < got.size()) r = got[i];
      check($sformatf("%s data[%0d]", name, i), r.data, exp_data_q[i]);
      check($sformatf("%s rs[%0d]", name, i), r.rs, exp_rs_q[i]);
      check($sformatf("%s en_len[%0d]", name, i), r.en_len, en_len);
      check($sformatf("%s stable[%0d]", name, i), r.ok, 1);
      if (i > 0)
        check($sformatf("%s gap[%0d]", name, i),
              (i < got.size()) ? got[i].start - got[i-1].start : -1, exp_gap_q[i-1]);
    end
  endtask

  initial begin
    vec_t vecs[12];
    longint lat;
    int guard;
    string nm;

    vecs[0]  = '{3'd2, 1'b1, 1'b1, 8'hC0, "RECORD"};
    vecs[1]  = '{3'd2, 1'b1, 1'b0, 8'h00, ""};
    vecs[2]  = '{3'd2, 1'b0, 1'b1, 8'h80, "RECORD"};
    vecs[3]  = '{3'd5, 1'b0, 1'b1, 8'h80, "PAUSE"};
    vecs[4]  = '{3'd1, 1'b1, 1'b1, 8'hC0, "IDLE"};
    vecs[5]  = '{3'd6, 1'b1, 1'b1, 8'hC0, ""};
    vecs[6]  = '{3'd6, 1'b1, 1'b0, 8'h00, ""};
    vecs[7]  = '{3'd0, 1'b0, 1'b1, 8'h80, ""};
    vecs[8]  = '{3'd3, 1'b0, 1'b1, 8'h80, "STOP"};
    vecs[9]  = '{3'd4, 1'b1, 1'b1, 8'hC0, "PLAY"};
    vecs[10] = '{3'd3, 1'b0, 1'b0, 8'h00, ""};
    vecs[11] = '{3'd5, 1'b0, 1'b1, 8'h80, "PAUSE"};

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; id_a = '0; id_b = '0; line_a = 1'b0; line_b = 1'b0;

    repeat (3) @(negedge clk);
    check("reset ready", rdy_a, 0);
    check("reset en", en_a, 0);
    check("reset data", data_a, 0);
    check("reset rs", rs_a, 0);
    check("const rw", rw_a, 0);
    check("const on", on_a, 1);
    check("const blon", blon_a, 0);
    check("B reset ready", rdy_b, 0);

    rst_a = 1'b0; rst_b = 1'b0;
    acc_cyc = cyc; rel_b = cyc;
    repeat (100) @(negedge clk);
    check("pwr wait data", data_a, 0);
    check("pwr wait en", en_a, 0);
    check("pwr wait ready", rdy_a, 0);
    waitReady(1'b0, 20000, lat);
    check("init latency", lat, INIT_A);
    expectInit(8'h38, 2052, 52, 22, 22, 767);
    checkOutput("init", 1'b0, 1);

    for (int i = 0; i < 12; i++) begin
      nm = $sformatf("msg%0d", i);
      applyStimulus(1'b0, vecs[i].id, vecs[i].line);
      waitReady(1'b0, 2000, lat);
      check({nm, " latency"}, lat, vecs[i].wr ? MSG_A : 0);
      if (vecs[i].wr) begin
        expectMessage(vecs[i].addr, vecs[i].text, 16, GAP_A);
      end else begin
        clearExpect();
        checkIdleQuiet(1'b0, nm);
      end
      checkOutput(nm, 1'b0, 1);
    end

    // A request raised mid-write must vanish, not run afterwards.
    applyStimulus(1'b0, 3'd1, 1'b0);
    repeat (100) @(negedge clk);
    valid_a = 1'b1; id_a = 3'd4; line_a = 1'b0;
    @(negedge clk);
    valid_a = 1'b0;
    waitReady(1'b0, 2000, lat);
    check("busy latency", lat, MSG_A);
    checkIdleQuiet(1'b0, "busy");
    expectMessage(8'h80, "IDLE", 16, GAP_A);
    checkOutput("busy", 1'b0, 1);

    // Reset while EN is high on char 5, then full re-init and forced rewrite.
    applyStimulus(1'b0, 3'd2, 1'b1);
    guard = 0;
    while (!(en_a && mon_a_q.size() == 6) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("char5 reached", guard < 1000, 1);
    check("char5 data", data_a, 8'h44);
    check("char5 rs", rs_a, 1);
    rst_a = 1'b1;
    #1;
    check("abort en", en_a, 0);
    check("abort data", data_a, 0);
    check("abort rs", rs_a, 0);
    check("abort ready", rdy_a, 0);
    repeat (3) @(negedge clk);
    mon_a_q.delete();
    rst_a = 1'b0;
    acc_cyc = cyc;
    waitReady(1'b0, 20000, lat);
    check("reinit latency", lat, INIT_A);
    expectInit(8'h38, 2052, 52, 22, 22, 767);
    checkOutput("reinit", 1'b0, 1);
    applyStimulus(1'b0, 3'd1, 1'b0);
    waitReady(1'b0, 2000, lat);
    check("rewrite latency", lat, MSG_A);
    expectMessage(8'h80, "IDLE", 16, GAP_A);
    checkOutput("rewrite", 1'b0, 1);

    // Single-line, 8-column instance.
    guard = 0;
    while (rdy_b_cyc < 0 && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    check("B init latency", rdy_b_cyc - rel_b, INIT_B);
    expectInit(8'h30, 8613, 213, 85, 85, 3216);
    checkOutput("B init", 1'b1, 2);
    applyStimulus(1'b1, 3'd7, 1'b1);
    waitReady(1'b1, 5000, lat);
    check("B msg latency", lat, MSG_B);
    expectMessage(8'h80, "", 8, GAP_B);
    checkOutput("B msg", 1'b1, 2);
    applyStimulus(1'b1, 3'd7, 1'b0);
    waitReady(1'b1, 5000, lat);
    check("B repeat latency", lat, 0);
    clearExpect();
    checkIdleQuiet(1'b1, "B repeat");
    checkOutput("B repeat", 1'b1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
